// File: rtl/ccr_wb_if.sv
// Result/flag handshake bundle between the upstream ALU, the write-back buffer and its consumer.
// Throughput one transfer per cycle per side; each side uses valid/ready.
interface ccr_wb_if #(
  parameter int OP_SIZE = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [OP_SIZE-1:0] in_r;
  logic [3:0]         in_ccr;
  logic               out_valid;
  logic               out_ready;
  logic [OP_SIZE-1:0] out_r;
  logic [3:0]         out_ccr;

  modport master (
    output in_valid, in_r, in_ccr, out_ready,
    input  in_ready, out_valid, out_r, out_ccr
  );

  modport slave (
    input  in_valid, in_r, in_ccr, out_ready,
    output in_ready, out_valid, out_r, out_ccr
  );
endinterface

// File: rtl/ccr_wb.sv
// 2-entry result/CCR write-back buffer with architectural commit, condition evaluator and optional
// sticky V (CCR_STICKY_V_EN); push->out_valid one cycle, in_ready depends only on registered occupancy.
module ccr_wb #(
  parameter int OP_SIZE = 4
) (
  input  logic               clk,
  input  logic               rst,
  ccr_wb_if.slave            bus,
  output logic [OP_SIZE-1:0] arch_r,
  output logic [3:0]         arch_ccr,
  input  logic [3:0]         cond_sel,
  output logic               cond_true,
  output logic [7:0]         commit_cnt,
  input  logic               sticky_clr,
  output logic               sticky_v
);

  typedef struct packed {
    logic [OP_SIZE-1:0] r;
    logic [3:0]         ccr;
  } ent_t;

  ent_t               ent0_q, ent0_d;
  ent_t               ent1_q, ent1_d;
  ent_t               new_ent;
  logic [1:0]         occ_q, occ_d;
  logic [OP_SIZE-1:0] arch_r_q, arch_r_d;
  logic [3:0]         arch_ccr_q, arch_ccr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               push, pop;
  logic               flag_c, flag_v, flag_n, flag_z;

  assign bus.in_ready  = (occ_q != 2'd2);
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.out_r     = bus.out_valid ? ent0_q.r   : '0;
  assign bus.out_ccr   = bus.out_valid ? ent0_q.ccr : 4'd0;

  assign push    = bus.in_valid & bus.in_ready;
  assign pop     = bus.out_valid & bus.out_ready;
  assign new_ent = '{r: bus.in_r, ccr: bus.in_ccr};

  // ent0 is always the head; a pop shifts ent1 down, a push fills the first free slot after the pop.
  always_comb begin
    ent0_d     = ent0_q;
    ent1_d     = ent1_q;
    arch_r_d   = arch_r_q;
    arch_ccr_d = arch_ccr_q;
    cnt_d      = cnt_q;
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    if (pop) begin
      ent0_d     = ent1_q;
      arch_r_d   = ent0_q.r;
      arch_ccr_d = ent0_q.ccr;
      cnt_d      = cnt_q + 8'd1;
    end
    if (push) begin
      if ((occ_q == 2'd0) || pop) begin
        ent0_d = new_ent;
      end else begin
        ent1_d = new_ent;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q     <= '0;
      ent1_q     <= '0;
      occ_q      <= 2'd0;
      arch_r_q   <= '0;
      arch_ccr_q <= 4'd0;
      cnt_q      <= 8'd0;
    end else begin
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      occ_q      <= occ_d;
      arch_r_q   <= arch_r_d;
      arch_ccr_q <= arch_ccr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign arch_r     = arch_r_q;
  assign arch_ccr   = arch_ccr_q;
  assign commit_cnt = cnt_q;

  assign {flag_c, flag_v, flag_n, flag_z} = arch_ccr_q;

  always_comb begin
    cond_true = 1'b0;
    case (cond_sel)
      4'h0: cond_true = 1'b1;
      4'h1: cond_true = 1'b0;
      4'h2: cond_true = flag_z;
      4'h3: cond_true = ~flag_z;
      4'h4: cond_true = flag_c;
      4'h5: cond_true = ~flag_c;
      4'h6: cond_true = flag_n;
      4'h7: cond_true = ~flag_n;
      4'h8: cond_true = flag_v;
      4'h9: cond_true = ~flag_v;
      4'hA: cond_true = (flag_n == flag_v);
      4'hB: cond_true = (flag_n != flag_v);
      4'hC: cond_true = ~flag_z & (flag_n == flag_v);
      4'hD: cond_true = flag_z | (flag_n != flag_v);
      4'hE: cond_true = ~flag_c & ~flag_z;
      default: cond_true = flag_c | flag_z;
    endcase
  end

`ifdef CCR_STICKY_V_EN
  logic sticky_q, sticky_d;

  // Set wins over clear so an overflow committed in the clearing cycle is not lost.
  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr) sticky_d = 1'b0;
    if (pop && ent0_q.ccr[2]) sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign sticky_v = sticky_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_v          = 1'b0;
`endif

endmodule

// File: tb/tb_ccr_wb.sv
// Bench for ccr_wb: queue-based reference model checked every cycle plus directed literal checks.
module tb_ccr_wb;
  localparam int W = 4;
`ifdef CCR_STICKY_V_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] arch_r;
  logic [3:0]   arch_ccr;
  logic [3:0]   cond_sel;
  logic         cond_true;
  logic [7:0]   commit_cnt;
  logic         sticky_clr;
  logic         sticky_v;

  ccr_wb_if #(.OP_SIZE(W)) bus ();

  ccr_wb #(.OP_SIZE(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .arch_r     (arch_r),
    .arch_ccr   (arch_ccr),
    .cond_sel   (cond_sel),
    .cond_true  (cond_true),
    .commit_cnt (commit_cnt),
    .sticky_clr (sticky_clr),
    .sticky_v   (sticky_v)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: a FIFO of {r,ccr} plus the last committed entry.
  typedef struct packed {
    logic [W-1:0] r;
    logic [3:0]   ccr;
  } ent_t;

  ent_t       mq[$];
  logic [W-1:0] m_arch_r;
  logic [3:0] m_arch_ccr;
  int         m_cnt;
  logic       m_sticky;
  bit         chk_en = 0;

  // Conditions come in complementary pairs: odd selects negate the even one.
  function automatic logic cond_model(input logic [3:0] sel, input logic [3:0] ccr);
    logic c, v, n, z, base;
    {c, v, n, z} = ccr;
    case (sel[3:1])
      3'd0: base = 1'b1;
      3'd1: base = z;
      3'd2: base = c;
      3'd3: base = n;
      3'd4: base = v;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = !c && !z;
    endcase
    return sel[0] ? !base : base;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_arch_r   = '0;
      m_arch_ccr = '0;
      m_cnt      = 0;
      m_sticky   = 1'b0;
      chk_en     = 1;
    end else begin
      bit   do_pop, do_push;
      ent_t e;
      do_pop  = (mq.size() > 0) && bus.out_ready;
      do_push = bus.in_valid && (mq.size() < 2);
      if (sticky_clr && STK) m_sticky = 1'b0;
      if (do_pop) begin
        e          = mq.pop_front();
        m_arch_r   = e.r;
        m_arch_ccr = e.ccr;
        m_cnt      = (m_cnt + 1) % 256;
        if (STK && e.ccr[2]) m_sticky = 1'b1;
      end
      if (do_push) mq.push_back('{r: bus.in_r, ccr: bus.in_ccr});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",   32'(bus.in_ready),  32'(mq.size() < 2));
      chk("out_valid",  32'(bus.out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("out_r",   32'(bus.out_r),   32'(mq[0].r));
        chk("out_ccr", 32'(bus.out_ccr), 32'(mq[0].ccr));
      end
      chk("arch_r",     32'(arch_r),     32'(m_arch_r));
      chk("arch_ccr",   32'(arch_ccr),   32'(m_arch_ccr));
      chk("commit_cnt", 32'(commit_cnt), 32'(m_cnt));
      chk("cond_true",  32'(cond_true),  32'(cond_model(cond_sel, m_arch_ccr)));
      chk("sticky_v",   32'(sticky_v),   32'(m_sticky));
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_r = '0; bus.in_ccr = '0;
    bus.out_ready = 1'b0; cond_sel = 4'h0; sticky_clr = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst in_ready",   32'(bus.in_ready),  32'd1);
    chk("rst out_valid",  32'(bus.out_valid), 32'd0);
    chk("rst out_r",      32'(bus.out_r),     32'd0);
    chk("rst arch_ccr",   32'(arch_ccr),      32'd0);
    chk("rst commit_cnt", 32'(commit_cnt),    32'd0);
    chk("rst sticky_v",   32'(sticky_v),      32'd0);

    // Single push then pop; N set.
    bus.in_valid = 1'b1; bus.in_r = 4'b1111; bus.in_ccr = 4'b1010;
    bus.out_ready = 1'b1; cond_sel = 4'h6;
    cyc();
    bus.in_valid = 1'b0;
    chk("t1 out_valid", 32'(bus.out_valid), 32'd1);
    chk("t1 out_r",     32'(bus.out_r),     32'hF);
    cyc();
    chk("t1 arch_ccr",  32'(arch_ccr),   32'hA);
    chk("t1 commit",    32'(commit_cnt), 32'd1);
    chk("t1 cond MI",   32'(cond_true),  32'd1);

    // Z-only flags and the EQ/NE/LS conditions.
    bus.in_valid = 1'b1; bus.in_r = 4'b0000; bus.in_ccr = 4'b0001;
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    chk("t2 arch_ccr", 32'(arch_ccr), 32'h1);
    cond_sel = 4'h2; #1; chk("t2 cond EQ", 32'(cond_true), 32'd1);
    cond_sel = 4'h3; #1; chk("t2 cond NE", 32'(cond_true), 32'd0);
    cond_sel = 4'hF; #1; chk("t2 cond LS", 32'(cond_true), 32'd1);

    // Push and pop together at occupancy 1.
    bus.in_valid = 1'b1; bus.in_r = 4'h9; bus.in_ccr = 4'h0;
    cyc();
    bus.in_r = 4'hA;
    cyc();
    bus.in_valid = 1'b0;
    chk("t3 head new", 32'(bus.out_r),    32'hA);
    chk("t3 in_ready", 32'(bus.in_ready), 32'd1);
    chk("t3 arch_r",   32'(arch_r),       32'h9);
    cyc();

    // Fill to two with the consumer stalled; third push must be dropped.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_r = 4'h3; bus.in_ccr = 4'h2; cyc();
    bus.in_r = 4'h5; bus.in_ccr = 4'h1; cyc();
    chk("t4 full in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_r = 4'h7; bus.in_ccr = 4'h8; cyc();
    bus.in_valid = 1'b0;
    chk("t4 hold out_r",   32'(bus.out_r),   32'h3);
    chk("t4 hold out_ccr", 32'(bus.out_ccr), 32'h2);
    bus.out_ready = 1'b1;
    cyc();
    chk("t4 pop1 arch_r", 32'(arch_r),    32'h3);
    chk("t4 next out_r",  32'(bus.out_r), 32'h5);
    cyc();
    chk("t4 pop2 arch_r", 32'(arch_r),        32'h5);
    chk("t4 empty",       32'(bus.out_valid), 32'd0);
    chk("t4 commit",      32'(commit_cnt),    32'd6);

    // Sticky overflow flag.
    bus.in_valid = 1'b1; bus.in_r = 4'b1000; bus.in_ccr = 4'b1110; cyc();
    bus.in_valid = 1'b0; cyc();
    chk("t5 sticky set", 32'(sticky_v), 32'(STK));
    cyc(); cyc();
    chk("t5 sticky hold", 32'(sticky_v), 32'(STK));
    sticky_clr = 1'b1; cyc();
    sticky_clr = 1'b0;
    chk("t5 sticky clr", 32'(sticky_v), 32'd0);
    bus.in_valid = 1'b1; bus.in_ccr = 4'h4; cyc();
    bus.in_valid = 1'b0; sticky_clr = 1'b1; cyc();
    sticky_clr = 1'b0;
    chk("t5 set beats clr", 32'(sticky_v), 32'(STK));

    // 256 commits from a clean reset wrap the counter.
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      bus.in_valid = 1'b1; bus.in_r = i[3:0]; bus.in_ccr = i[5:2];
      cyc();
    end
    bus.in_valid = 1'b0;
    chk("t6 commit 255", 32'(commit_cnt), 32'hFF);
    cyc();
    chk("t6 commit wrap", 32'(commit_cnt), 32'd0);
    chk("t6 arch_ccr",    32'(arch_ccr),   32'hF);

    // Reset with two entries buffered, push/pop offered during reset.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_r = 4'h6; bus.in_ccr = 4'h5; cyc();
    bus.in_r = 4'hC; cyc();
    chk("t7 full", 32'(bus.in_ready), 32'd0);
    rst = 1'b1; bus.out_ready = 1'b1; cyc();
    rst = 1'b0; bus.in_valid = 1'b0;
    chk("t7 out_valid", 32'(bus.out_valid), 32'd0);
    chk("t7 arch_ccr",  32'(arch_ccr),      32'd0);
    chk("t7 commit",    32'(commit_cnt),    32'd0);
    chk("t7 in_ready",  32'(bus.in_ready),  32'd1);
    chk("t7 out_r",     32'(bus.out_r),     32'd0);
    cyc();
    chk("t7 still empty", 32'(bus.out_valid), 32'd0);

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ccr_wb.md
CCR_WB -- requirements
Module: ccr_wb

Interface
REQ-001 Parameter: OP_SIZE, default 4, result width in bits.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  in  1  upstream result present.
REQ-005 Port: in_ready  out  1  block accepts a result this cycle.
REQ-006 Port: in_r  in  OP_SIZE  upstream result R.
REQ-007 Port: in_ccr  in  4  upstream flags, bit order C,V,N,Z (bit3..bit0).
REQ-008 Port: out_valid  out  1  buffered result available to commit.
REQ-009 Port: out_ready  in  1  consumer takes head entry.
REQ-010 Port: out_r  out  OP_SIZE  head-entry result.
REQ-011 Port: out_ccr  out  4  head-entry flags, CVNZ.
REQ-012 Port: arch_r  out  OP_SIZE  last committed result.
REQ-013 Port: arch_ccr  out  4  last committed flags, CVNZ.
REQ-014 Port: cond_sel  in  4  branch-condition select.
REQ-015 Port: cond_true  out  1  selected condition evaluated on arch_ccr.
REQ-016 Port: commit_cnt  out  8  number of commits, modulo 256.
REQ-017 Port: sticky_clr  in  1  clears sticky_v.
REQ-018 Port: sticky_v  out  1  sticky overflow flag (see Configuration).

Function
REQ-019 The block SHALL buffer {in_r, in_ccr} in a 2-entry FIFO; push = in_valid & in_ready, pop = out_valid & out_ready.
REQ-020 in_ready SHALL be driven from registered occupancy only: 1 when occupancy < 2; no combinational path from out_ready.
REQ-021 out_valid SHALL be 1 when occupancy != 0; out_r/out_ccr SHALL show the oldest entry and hold stable while out_valid & !out_ready.
REQ-022 Latency: an entry pushed at edge N SHALL appear at out_* with out_valid=1 after edge N (no bypass).
REQ-023 Push and pop in the same cycle at occupancy 1 SHALL leave occupancy 1 with the new entry at head; at occupancy 2 no push occurs.
REQ-024 Pop at occupancy 0 is impossible (out_valid=0); in_valid while in_ready=0 SHALL be ignored, upstream holds data.
REQ-025 On pop, arch_r/arch_ccr SHALL load the popped entry and commit_cnt SHALL increment, wrapping 255 -> 0.
REQ-026 cond_true SHALL be combinational from arch_ccr and cond_sel: 0 always1, 1 never, 2 EQ Z, 3 NE !Z, 4 CS C, 5 CC !C, 6 MI N, 7 PL !N, 8 VS V, 9 VC !V, A GE N==V, B LT N!=V, C GT !Z&(N==V), D LE Z|(N!=V), E HI !C&!Z, F LS C|Z.
REQ-027 Flags SHALL be passed through unmodified; the block performs no arithmetic on in_r.

Reset
REQ-028 On rst=1 at a clock edge: occupancy 0, out_valid 0, in_ready 1, arch_r 0, arch_ccr 0000, commit_cnt 0, sticky_v 0; out_r/out_ccr SHALL read 0.
REQ-029 rst mid-operation SHALL discard both buffered entries; a push or pop in the reset cycle SHALL have no effect.

Configuration
REQ-030 Macro CCR_STICKY_V_EN: when defined, sticky_v SHALL set on any pop whose V bit is 1 and clear on sticky_clr=1; simultaneous set and clear SHALL leave sticky_v=1.
REQ-031 When CCR_STICKY_V_EN is undefined, sticky_v SHALL be constant 0, sticky_clr SHALL be ignored, and no sticky register SHALL be synthesised.

Verification
REQ-032 Reset, then push in_r=1111 in_ccr=1010 with out_ready=1 -> out_valid next cycle, after pop arch_ccr=1010, commit_cnt=1, cond_sel=6 gives cond_true=1.
REQ-033 Push in_r=0000 in_ccr=0001, pop -> arch_ccr=0001, cond_sel=2 gives 1, cond_sel=3 gives 0, cond_sel=F gives 1.
REQ-034 out_ready=0, push three entries back-to-back -> in_ready=0 after second push, third ignored, out_* hold first entry; release out_ready -> first two entries popped in order.
REQ-035 Push in_r=1000 in_ccr=1110, pop -> with CCR_STICKY_V_EN sticky_v=1 until sticky_clr pulse; without macro sticky_v stays 0.
REQ-036 256 commits -> commit_cnt wraps to 0; assert rst with 2 entries buffered -> out_valid=0, arch_ccr=0000 next cycle.
